imem_fetch_if: RTL and testbench
================================

Name: imem_fetch_if

Overview:
Instruction-fetch bus interface that sits directly upstream of the pipelined datapath's fetch stage. It consumes PCF and supplies instrF. It fetches from a variable-latency instruction memory over a req/gnt/rvalid bus and holds fetched words in a tagged buffer. On a buffer miss it raises fetch_stall; the hazard unit turns this into stallF plus flushD, so decode receives bubbles until the word arrives.

Parameters:
NOP_INSTR, 32'h00000013, word driven on instrF on miss or error (addi x0,x0,0)
TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before bus error (8-bit counter, range 1..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
pcf  input  32  fetch PC from datapath (PCF)
instrF  output  32  instruction for pcf, or NOP_INSTR
fetch_stall  output  1  high when instrF is not valid for pcf
imem_req  output  1  read request
imem_addr  output  32  word-aligned request address, low 2 bits always 0
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
bus_err  output  1  sticky timeout flag

Behaviour:
- Reset is asynchronous, active-low on rst. While low: all buffer valid bits = 0, FSM = IDLE, imem_req = 0, imem_addr = 0, timeout counter = 0, bus_err = 0. Combinationally, instrF = NOP_INSTR and fetch_stall = 1.
- Buffer entry fields: valid, tag[29:0] (= addr[31:2]), data[31:0].
- hit = valid && tag == pcf[31:2]. pcf[1:0] is ignored.
- Outputs are combinational from buffer state and pcf:
  - instrF = hit ? data : NOP_INSTR
  - fetch_stall = !hit || bus_err
  - if bus_err = 1, instrF = NOP_INSTR
- FSM states, registered:
  - IDLE: if !hit and !bus_err, latch req_addr = {pcf[31:2], 2'b00} and go to REQ.
  - REQ: imem_req = 1, imem_addr = req_addr. Address stays stable until gnt. On imem_gnt, go to WAIT.
  - WAIT: imem_req = 0. On imem_rvalid, write entry (valid = 1, tag = req_addr[31:2], data = imem_rdata) and go to IDLE.
- Protocol:
  - At most one outstanding request.
  - rvalid arrives at least 1 cycle after gnt; rvalid in the gnt cycle is ignored.
  - rvalid outside WAIT is ignored.
- Miss latency with zero-wait memory (gnt in first REQ cycle, rvalid next cycle): miss seen in IDLE at cycle 0, REQ at 1, WAIT at 2, fill at the end of cycle 2, hit at cycle 3.
- Redirect (pcf changes) while in REQ/WAIT: the transaction always completes and fills with the latched tag. The hit check uses the current pcf; a mismatch then triggers a new request from IDLE. No abort.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES: bus_err <= 1 (sticky until rst), FSM goes to IDLE, no fill.
  - While bus_err = 1: no new requests.
- Simultaneous gnt and a pcf change in REQ: gnt is honoured with the latched address.

Optional Feature:
Macro: NEXT_LINE_PREFETCH_EN
- Defined:
  - Buffer has two entries; hit is the OR over both entries.
  - In IDLE, when pcf hits, no entry holds pcf+4, and !bus_err: issue a prefetch for {pcf[31:2]+1, 2'b00}, wrapping 0xFFFFFFFC to 0x00000000.
  - Prefetch fill goes to the entry not hitting pcf at request-latch time.
  - Demand-miss fill goes to entry 0 and invalidates entry 1 in the same cycle.
  - A demand miss arising during a prefetch waits for that prefetch to complete.
  - Demand misses always have priority over prefetch in IDLE.
- Undefined: single entry (entry 0 only), no prefetch logic.

Test Plan:
- Reset then pcf=0x0; mem returns 0x00500093 with gnt same cycle and rvalid +1 -> fetch_stall=1 and instrF=0x00000013 for cycles 0-2; cycle 3 instrF=0x00500093, fetch_stall=0; exactly one req with imem_addr=0x0.
- pcf=0x4 held after a fill; gnt delayed 5 cycles -> imem_addr stays 0x4 with imem_req=1 for all 5 cycles; stall until 2 cycles after gnt.
- Redirect pcf 0x8 -> 0x40 while in WAIT -> fill tag 0x8 completes, second request to 0x40; instrF correct for 0x40 only after second rvalid.
- Never assert gnt, TIMEOUT_CYCLES=16 -> bus_err=1 after 16 cycles; imem_req=0 thereafter; fetch_stall=1, instrF=NOP until rst low; after reset bus_err=0.
- rst asserted low in WAIT, then rvalid pulses -> buffer empty, rvalid ignored, new request issued after reset release.
- NEXT_LINE_PREFETCH_EN: sequential pcf 0x0, 0x4, 0x8 with 1-cycle memory -> after first fill, a prefetch for 0x4 is issued; the step to 0x4 has 0 stall cycles; pcf=0xFFFFFFFC prefetches 0x00000000.

Source files
------------

// File: rtl/imem_fetch_if_if.sv
// Instruction-memory bus bundle between the fetch interface and the memory.
//   imem_req    : read request, held until imem_gnt
//   imem_addr   : word-aligned request address
//   imem_gnt    : request accepted this cycle
//   imem_rvalid : read data valid
//   imem_rdata  : read data
// master = fetch interface side, slave = memory side.
interface imem_fetch_if_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/imem_fetch_if.sv
// Instruction-fetch bus interface. Looks up pcf in a tagged word buffer,
// returns the instruction on a hit, otherwise drives NOP_INSTR, raises
// fetch_stall and fetches the word over a req/gnt/rvalid bus. A request that
// stays in REQ+WAIT for TIMEOUT_CYCLES cycles sets the sticky bus_err flag,
// which blocks all further requests until reset.
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active-low
//   pcf         : fetch PC (bits [1:0] ignored)
//   instrF      : instruction for pcf, or NOP_INSTR
//   fetch_stall : instrF is not valid for pcf
//   bus_err     : sticky timeout flag
//   imem        : memory bus (master modport)
//
// Optional feature, macro NEXT_LINE_PREFETCH_EN: two-entry buffer plus a
// next-line prefetch issued from IDLE while pcf hits. Undefined: one entry.
//
// state  | meaning
// S_IDLE | no transaction; demand miss or prefetch may start
// S_REQ  | imem_req high with latched address, waiting for gnt
// S_WAIT | granted, waiting for rvalid to fill the buffer
module imem_fetch_if #(
  parameter logic [31:0] NOP_INSTR      = 32'h00000013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pcf,
  output logic [31:0]            instrF,
  output logic                   fetch_stall,
  output logic                   bus_err,
  imem_fetch_if_if.master        imem
);

`ifdef NEXT_LINE_PREFETCH_EN
  localparam int NUM_ENT = 2;
`else
  localparam int NUM_ENT = 1;
`endif
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [29:0] req_tag_q, req_tag_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        fill;

  logic        valid_q [NUM_ENT];
  logic [29:0] tag_q   [NUM_ENT];
  logic [31:0] data_q  [NUM_ENT];

  logic [NUM_ENT-1:0] ent_hit;
  logic               hit;
  logic [31:0]        hit_data;
  logic [7:0]         cnt_inc;
  logic               pcf_unused;

  assign pcf_unused = ^pcf[1:0];
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    ent_hit  = '0;
    hit_data = NOP_INSTR;
    for (int i = 0; i < NUM_ENT; i++) begin
      ent_hit[i] = valid_q[i] && (tag_q[i] == pcf[31:2]);
      if (ent_hit[i]) hit_data = data_q[i];
    end
  end
  assign hit = |ent_hit;

`ifdef NEXT_LINE_PREFETCH_EN
  logic        pf_q, pf_d;
  logic        pf_slot_q, pf_slot_d;
  logic [29:0] next_tag;
  logic        next_hit;

  // 30-bit add wraps 0xFFFFFFFC to 0x00000000 naturally
  assign next_tag = pcf[31:2] + 30'd1;

  always_comb begin
    next_hit = 1'b0;
    for (int i = 0; i < NUM_ENT; i++)
      if (valid_q[i] && (tag_q[i] == next_tag)) next_hit = 1'b1;
  end
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      req_tag_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
`ifdef NEXT_LINE_PREFETCH_EN
      pf_q      <= 1'b0;
      pf_slot_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_tag_q <= req_tag_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`ifdef NEXT_LINE_PREFETCH_EN
      pf_q      <= pf_d;
      pf_slot_q <= pf_slot_d;
`endif
    end
  end

  // next-state logic; the counter runs across REQ and WAIT, and a gnt or
  // rvalid in the final cycle still completes the transaction
  always_comb begin
    state_d   = state_q;
    req_tag_d = req_tag_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    fill      = 1'b0;
`ifdef NEXT_LINE_PREFETCH_EN
    pf_d      = pf_q;
    pf_slot_d = pf_slot_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!err_q && !hit) begin
          state_d   = S_REQ;
          req_tag_d = pcf[31:2];
          cnt_d     = '0;
`ifdef NEXT_LINE_PREFETCH_EN
          pf_d      = 1'b0;
        end else if (!err_q && !next_hit) begin
          state_d   = S_REQ;
          req_tag_d = next_tag;
          cnt_d     = '0;
          pf_d      = 1'b1;
          // fill the entry that does not hold the current pcf
          pf_slot_d = ent_hit[0];
`endif
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (imem.imem_gnt) begin
          state_d = S_WAIT;
        end else if (cnt_inc == TO_LIMIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (imem.imem_rvalid) begin
          state_d = S_IDLE;
          fill    = 1'b1;
        end else if (cnt_inc == TO_LIMIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // buffer write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (fill) begin
`ifdef NEXT_LINE_PREFETCH_EN
      if (pf_q) begin
        valid_q[pf_slot_q] <= 1'b1;
        tag_q[pf_slot_q]   <= req_tag_q;
        data_q[pf_slot_q]  <= imem.imem_rdata;
      end else begin
        valid_q[0] <= 1'b1;
        tag_q[0]   <= req_tag_q;
        data_q[0]  <= imem.imem_rdata;
        valid_q[1] <= 1'b0;
      end
`else
      valid_q[0] <= 1'b1;
      tag_q[0]   <= req_tag_q;
      data_q[0]  <= imem.imem_rdata;
`endif
    end
  end

  // outputs
  always_comb begin
    imem.imem_req  = (state_q == S_REQ);
    imem.imem_addr = {req_tag_q, 2'b00};
    instrF         = (hit && !err_q) ? hit_data : NOP_INSTR;
    fetch_stall    = !hit || err_q;
    bus_err        = err_q;
  end

endmodule

// File: tb/tb_imem_fetch_if.sv
module tb_imem_fetch_if;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pcf = 32'h0;
  logic [31:0] instrF;
  logic        fetch_stall;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  int grants   = 0;
  int gnt_delay = 0;
  int rv_delay  = 1;
  bit gnt_en    = 1'b1;
  logic [31:0] exp_q [$];

  imem_fetch_if_if bus ();

  imem_fetch_if #(.NOP_INSTR(NOP), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .pcf(pcf), .instrF(instrF),
    .fetch_stall(fetch_stall), .bus_err(bus_err), .imem(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00500093 + (a << 8);
  endfunction

  // memory model: grants after gnt_delay REQ cycles, returns data rv_delay
  // cycles after the grant; granted addresses are checked against exp_q
  initial begin : responder
    int req_cycles;
    int rv_cnt;
    logic [31:0] rv_addr;
    logic [31:0] exp_a;
    req_cycles = 0; rv_cnt = 0; rv_addr = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(rv_addr);
        end
      end
      if (bus.imem_req === 1'b1) begin
        req_cycles++;
        if (gnt_en && req_cycles > gnt_delay) begin
          bus.imem_gnt = 1'b1;
          req_cycles = 0;
          grants++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_addr: got request to %h, expected no request", bus.imem_addr);
          end else begin
            exp_a = exp_q.pop_front();
            if (bus.imem_addr !== exp_a) begin
              n_fail++;
              $display("FAIL req_addr: got %h expected %h", bus.imem_addr, exp_a);
            end
          end
          rv_addr = bus.imem_addr;
          rv_cnt  = rv_delay;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b0; pcf = 32'h0;
    repeat (2) @(negedge clk); #1;
    n_checks++; if (instrF !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h expected %h", instrF, NOP); end
    n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b expected 1", fetch_stall); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", bus.imem_addr); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", bus_err); end
  endtask

  task automatic test_miss_zero_wait();
    int g0;
    gnt_delay = 0; rv_delay = 1; gnt_en = 1'b1; g0 = grants;
    exp_q.push_back(32'h0);
    @(negedge clk); rst = 1'b1; pcf = 32'h0; #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b1, NOP}) begin n_fail++; $display("FAIL zw_c0: got %b/%h expected 1/%h", fetch_stall, instrF, NOP); end
    @(negedge clk); #1;
    n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL zw_c1_req: got %b/%h expected 1/0", bus.imem_req, bus.imem_addr); end
    n_checks++; if ({fetch_stall, instrF} !== {1'b1, NOP}) begin n_fail++; $display("FAIL zw_c1: got %b/%h expected 1/%h", fetch_stall, instrF, NOP); end
    @(negedge clk); #1;
    n_checks++; if ({bus.imem_req, fetch_stall, instrF} !== {1'b0, 1'b1, NOP}) begin n_fail++; $display("FAIL zw_c2: got %b/%b/%h expected 0/1/%h", bus.imem_req, fetch_stall, instrF, NOP); end
    @(negedge clk); #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, 32'h00500093}) begin n_fail++; $display("FAIL zw_c3: got %b/%h expected 0/00500093", fetch_stall, instrF); end
    n_checks++; if (grants - g0 !== 1) begin n_fail++; $display("FAIL zw_grants: got %0d expected 1", grants - g0); end
  endtask

  task automatic test_gnt_delay();
    gnt_delay = 5;
    @(negedge clk); pcf = 32'h4; exp_q.push_back(32'h4); #1;
    n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL gd_c0_stall: got %b expected 1", fetch_stall); end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr, fetch_stall} !== {1'b1, 32'h4, 1'b1}) begin
        n_fail++; $display("FAIL gd_req_c%0d: got %b/%h/%b expected 1/00000004/1", i, bus.imem_req, bus.imem_addr, fetch_stall);
      end
    end
    @(negedge clk); #1;
    n_checks++; if ({bus.imem_req, fetch_stall} !== 2'b01) begin n_fail++; $display("FAIL gd_wait: got %b/%b expected 0/1", bus.imem_req, fetch_stall); end
    @(negedge clk); #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'h4)}) begin n_fail++; $display("FAIL gd_hit: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'h4)); end
    gnt_delay = 0;
  endtask

  task automatic test_redirect();
    int n;
    rv_delay = 3;
    @(negedge clk); pcf = 32'h8; exp_q.push_back(32'h8);
    @(negedge clk);
    @(negedge clk); pcf = 32'h40; exp_q.push_back(32'h40); #1;
    n_checks++; if ({bus.imem_req, fetch_stall} !== 2'b01) begin n_fail++; $display("FAIL rd_wait: got %b/%b expected 0/1", bus.imem_req, fetch_stall); end
    repeat (3) @(negedge clk);
    pcf = 32'h8; #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'h8)}) begin n_fail++; $display("FAIL rd_tag8: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'h8)); end
    @(negedge clk); pcf = 32'h40; #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b1, NOP}) begin n_fail++; $display("FAIL rd_miss40: got %b/%h expected 1/%h", fetch_stall, instrF, NOP); end
    n = 0;
    do begin @(negedge clk); #1; n++; end while (fetch_stall && n < 20);
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'h40)}) begin n_fail++; $display("FAIL rd_hit40: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'h40)); end
    pcf = 32'h43; #1;
    n_checks++; if (instrF !== mem_word(32'h40)) begin n_fail++; $display("FAIL rd_lowbits: got %h expected %h", instrF, mem_word(32'h40)); end
    rv_delay = 1;
  endtask

  task automatic test_high_addr();
    int n;
    @(negedge clk); pcf = 32'hFFFFFFFF; exp_q.push_back(32'hFFFFFFFC);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (fetch_stall && n < 20);
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'hFFFFFFFC)}) begin n_fail++; $display("FAIL hi_hit: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'hFFFFFFFC)); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hi_queue: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    gnt_en = 1'b0;
    @(negedge clk); pcf = 32'h100; #1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.imem_req, bus_err} !== 2'b10) begin n_fail++; $display("FAIL to_req_c%0d: got %b/%b expected 1/0", i, bus.imem_req, bus_err); end
    end
    @(negedge clk); #1;
    n_checks++; if ({bus.imem_req, bus_err} !== 2'b01) begin n_fail++; $display("FAIL to_err: got %b/%b expected 0/1", bus.imem_req, bus_err); end
    gnt_en = 1'b1;
    pcf = 32'hFFFFFFFC; #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b1, NOP}) begin n_fail++; $display("FAIL to_nop: got %b/%h expected 1/%h", fetch_stall, instrF, NOP); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.imem_req, bus_err, fetch_stall} !== 3'b011) begin n_fail++; $display("FAIL to_hold_%0d: got %b/%b/%b expected 0/1/1", i, bus.imem_req, bus_err, fetch_stall); end
    end
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_rst_err: got %b expected 0", bus_err); end
  endtask

  task automatic test_reset_in_wait();
    int g0;
    int n;
    rv_delay = 4; g0 = grants;
    pcf = 32'h200; exp_q.push_back(32'h200);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if ({bus.imem_req, fetch_stall} !== 2'b01) begin n_fail++; $display("FAIL rw_wait: got %b/%b expected 0/1", bus.imem_req, fetch_stall); end
    rst = 1'b0; rv_delay = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.imem_req, fetch_stall} !== 2'b01) begin n_fail++; $display("FAIL rw_inrst_%0d: got %b/%b expected 0/1", i, bus.imem_req, fetch_stall); end
    end
    exp_q.push_back(32'h200);
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b1, NOP}) begin n_fail++; $display("FAIL rw_empty: got %b/%h expected 1/%h", fetch_stall, instrF, NOP); end
    n = 0;
    do begin @(negedge clk); #1; n++; end while (fetch_stall && n < 20);
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'h200)}) begin n_fail++; $display("FAIL rw_refill: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'h200)); end
    n_checks++; if (grants - g0 !== 2) begin n_fail++; $display("FAIL rw_grants: got %0d expected 2", grants - g0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rw_queue: got %0d pending expected 0", exp_q.size()); end
  endtask

`ifdef NEXT_LINE_PREFETCH_EN
  task automatic test_prefetch();
    int n;
    gnt_delay = 0; rv_delay = 1; gnt_en = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    @(negedge clk); rst = 1'b1; pcf = 32'h0;
    repeat (3) @(negedge clk); #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'h0)}) begin n_fail++; $display("FAIL pf_hit0: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'h0)); end
    @(negedge clk); #1;
    n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL pf_req4: got %b/%h expected 1/00000004", bus.imem_req, bus.imem_addr); end
    repeat (2) @(negedge clk);
    pcf = 32'h4; exp_q.push_back(32'h8); #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'h4)}) begin n_fail++; $display("FAIL pf_step4: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'h4)); end
    repeat (3) @(negedge clk);
    pcf = 32'h8; exp_q.push_back(32'hC); #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'h8)}) begin n_fail++; $display("FAIL pf_step8: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'h8)); end
    repeat (3) @(negedge clk);
    pcf = 32'hFFFFFFFC; exp_q.push_back(32'hFFFFFFFC); exp_q.push_back(32'h0); #1;
    n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL pf_miss_hi: got %b expected 1", fetch_stall); end
    n = 0;
    do begin @(negedge clk); #1; n++; end while (fetch_stall && n < 20);
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'hFFFFFFFC)}) begin n_fail++; $display("FAIL pf_hit_hi: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'hFFFFFFFC)); end
    repeat (3) @(negedge clk);
    pcf = 32'h0; exp_q.push_back(32'h4); #1;
    n_checks++; if ({fetch_stall, instrF} !== {1'b0, mem_word(32'h0)}) begin n_fail++; $display("FAIL pf_wrap0: got %b/%h expected 0/%h", fetch_stall, instrF, mem_word(32'h0)); end
    repeat (4) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pf_queue: got %0d pending expected 0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef NEXT_LINE_PREFETCH_EN
    test_prefetch();
`else
    test_miss_zero_wait();
    test_gnt_delay();
    test_redirect();
    test_high_addr();
    test_timeout();
    test_reset_in_wait();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
